// File: rtl/lane_serializer.sv
// Captures a LANES-wide word and shifts it out LSB first over a valid/ready link.
// A one-word holding register keeps upstream streaming while the shifter is busy.
//
// state | meaning
// IDLE  | shifter empty, ser_valid_o low
// SHIFT | shifter holds a word, ser_o carries bit cnt of it
module lane_serializer #(
  parameter int LANES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [LANES-1:0] lane_i,
  input  logic             lane_valid_i,
  output logic             lane_ready_o,
  output logic             ser_o,
  output logic             ser_valid_o,
  output logic             ser_last_o,
  input  logic             ser_ready_i
);

  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [LANES-1:0] sh, sh_n;
  logic [LANES-1:0] hold, hold_n;
  logic             hold_v, hold_v_n;
  logic [CW-1:0]    cnt, cnt_n;

  logic busy, acc, out, fin, free;

  assign busy         = (state == SHIFT);
  assign lane_ready_o = !hold_v;
  assign ser_o        = sh[0];
  assign ser_valid_o  = busy;
  assign ser_last_o   = busy && (cnt == CW'(LANES - 1));

  assign acc  = lane_valid_i && lane_ready_o;
  assign out  = ser_valid_o && ser_ready_i;
  assign fin  = out && ser_last_o;
  assign free = !busy || fin;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      sh     <= '0;
      hold   <= '0;
      hold_v <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      sh     <= sh_n;
      hold   <= hold_n;
      hold_v <= hold_v_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    sh_n     = sh;
    hold_n   = hold;
    hold_v_n = hold_v;
    cnt_n    = cnt;
    if (free) begin
      // The held word is older than anything on lane_i, so it loads first.
      if (hold_v) begin
        sh_n     = hold;
        hold_v_n = 1'b0;
        cnt_n    = '0;
        state_n  = SHIFT;
      end else if (acc) begin
        sh_n    = lane_i;
        cnt_n   = '0;
        state_n = SHIFT;
      end else begin
        state_n = IDLE;
      end
    end else begin
      if (acc) begin
        hold_n   = lane_i;
        hold_v_n = 1'b1;
      end
      if (out) begin
        sh_n  = sh >> 1;
        cnt_n = cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Bench for lane_serializer: directed test-plan steps plus random traffic,
// checked against a word-queue model of the serial stream.
module tb_lane_serializer;

  localparam int LANES = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [LANES-1:0] lane_i;
  logic             lane_valid_i;
  logic             lane_ready_o;
  logic             ser_o;
  logic             ser_valid_o;
  logic             ser_last_o;
  logic             ser_ready_i;

  lane_serializer #(.LANES(LANES)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lane_i       (lane_i),
    .lane_valid_i (lane_valid_i),
    .lane_ready_o (lane_ready_o),
    .ser_o        (ser_o),
    .ser_valid_o  (ser_valid_o),
    .ser_last_o   (ser_last_o),
    .ser_ready_i  (ser_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Model: pending serial bits with their last flags, and words not yet fully sent.
  bit expq[$];
  bit lastq[$];
  bit got[$];
  int outstanding = 0;
  bit last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks pre-edge outputs, updates model.
  task automatic cyc(input logic v, input logic [LANES-1:0] d, input logic r);
    bit acc, out, b, lst;
    lane_valid_i = v;
    lane_i       = d;
    ser_ready_i  = r;
    #1;
    chk("lane_ready", {31'd0, lane_ready_o}, {31'd0, outstanding < 2});
    chk("ser_valid", {31'd0, ser_valid_o}, {31'd0, outstanding > 0});
    if (outstanding > 0) begin
      chk("ser_bit", {31'd0, ser_o}, {31'd0, expq[0]});
      chk("ser_last", {31'd0, ser_last_o}, {31'd0, lastq[0]});
    end
    acc = v && (outstanding < 2);
    out = (outstanding > 0) && r;
    @(posedge clk_i);
    if (out) begin
      b   = expq.pop_front();
      lst = lastq.pop_front();
      got.push_back(b);
      if (lst) outstanding--;
    end
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        expq.push_back(d[i]);
        lastq.push_back(i == LANES - 1);
      end
      outstanding++;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
  endtask

  // Compare captured serial bits against a literal, bit i = i-th bit sent.
  task automatic chk_stream(input string tag, input logic [15:0] exp, input int n);
    chk({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk(tag, {31'd0, got[i]}, {31'd0, exp[i]});
    got.delete();
  endtask

  // Assert reset away from the clock edge and check outputs immediately.
  task automatic do_reset();
    #1;
    rst_i = 1'b1;
    #1;
    chk("rst_ser", {31'd0, ser_o}, 32'd0);
    chk("rst_valid", {31'd0, ser_valid_o}, 32'd0);
    chk("rst_last", {31'd0, ser_last_o}, 32'd0);
    chk("rst_ready", {31'd0, lane_ready_o}, 32'd1);
    expq.delete();
    lastq.delete();
    got.delete();
    outstanding = 0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    lane_i       = '0;
    lane_valid_i = 1'b0;
    ser_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("init_valid", {31'd0, ser_valid_o}, 32'd0);
    chk("init_ready", {31'd0, lane_ready_o}, 32'd1);
    chk("init_ser", {31'd0, ser_o}, 32'd0);
    rst_i = 1'b0;
    idle(2);

    // single word
    cyc(1'b1, 4'ha, 1'b1);
    idle(5);
    chk_stream("single", 16'h000a, 4);

    // back-to-back, no bubble
    cyc(1'b1, 4'ha, 1'b1);
    cyc(1'b1, 4'h5, 1'b1);
    idle(9);
    chk_stream("b2b", 16'h005a, 8);

    // backpressure
    cyc(1'b1, 4'hc, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    idle(3);
    chk_stream("bp", 16'h000c, 4);

    // full: two words stored, third pending
    cyc(1'b1, 4'h3, 1'b0);
    cyc(1'b1, 4'h9, 1'b0);
    chk("full_ready", {31'd0, lane_ready_o}, 32'd0);
    cyc(1'b1, 4'h6, 1'b0);
    cyc(1'b1, 4'h6, 1'b0);
    last_acc = 1'b0;
    for (int i = 0; i < 12 && !last_acc; i++) cyc(1'b1, 4'h6, 1'b1);
    chk("full_accept6", {31'd0, last_acc}, 32'd1);
    idle(14);
    chk_stream("full", 16'h0693, 12);

    // reset mid-word
    cyc(1'b1, 4'hf, 1'b1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    do_reset();
    cyc(1'b1, 4'h2, 1'b1);
    idle(6);
    chk_stream("rst_mid", 16'h0002, 4);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else cyc(1'($urandom_range(0, 1)), LANES'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    idle(20);
    chk("drain_empty", outstanding, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lane_serializer.md
# lane_serializer

Downstream stage for the per-lane generate array: it captures the LANES-wide vector of per-lane bits (lane n driven by generated instance n) and shifts it out bit-serially, LSB (lane 0) first, over a valid/ready link. One word of elastic storage beside the shift register keeps the upstream side streaming while a word is being shifted out.

## Interface
- LANES, 4, number of lanes per word (legal range 2..32)
- clk_i  input  1  clock, all state on rising edge
- rst_i  input  1  reset, asynchronous and active-high
- lane_i  input  LANES  parallel word; bit n = output of lane n
- lane_valid_i  input  1  lane_i holds a word
- lane_ready_o  output  1  block can accept a word this cycle
- ser_o  output  1  current serial bit
- ser_valid_o  output  1  ser_o is valid
- ser_last_o  output  1  ser_o is bit LANES-1 of its word
- ser_ready_i  input  1  sink accepts ser_o this cycle

## Operation
- Storage: shift register sh[LANES-1:0], bit counter cnt (width clog2(LANES)), busy flag; holding register hold[LANES-1:0] with hold_v.
- Two-state FSM: IDLE (busy=0), SHIFT (busy=1).
- lane_ready_o = !hold_v (combinational from state; never depends on lane_valid_i).
- Input handshake at edge: acc = lane_valid_i & lane_ready_o.
- Output handshake at edge: out = ser_valid_o & ser_ready_i; fin = out & ser_last_o.
- free = IDLE | fin (shifter becomes empty at this edge).
- At each edge, in priority:
  - free & hold_v: sh <= hold, hold_v <= 0, cnt <= 0, stay/enter SHIFT (hold is older; acc is impossible since ready=0).
  - free & !hold_v & acc: sh <= lane_i, cnt <= 0, enter SHIFT.
  - free & nothing to load: enter IDLE.
  - !free & acc: hold <= lane_i, hold_v <= 1.
  - out & !fin: sh <= sh >> 1, cnt <= cnt + 1.
- ser_o = sh[0]; ser_valid_o = busy; ser_last_o = busy & (cnt == LANES-1).
- While ser_valid_o & !ser_ready_i: ser_o, ser_last_o, sh, cnt hold constant.
- Words never dropped, reordered or duplicated; bits of a word are contiguous on the serial side.
- cnt never exceeds LANES-1; no wrap beyond a word.

## Timing
- Reset (asserted, asynchronous): IDLE, hold_v=0, sh=0, cnt=0; outputs ser_o=0, ser_valid_o=0, ser_last_o=0, lane_ready_o=1.
- Reset mid-word: in-flight and held words are discarded immediately; first post-reset word starts fresh at bit 0.
- Latency: word accepted at edge k -> bit 0 on ser_o with ser_valid_o=1 in the cycle after edge k.
- Throughput: with ser_ready_i held 1, one bit per cycle; back-to-back words with zero gap cycles (next word loaded on fin edge from hold or lane_i).
- Full: shifting + hold_v=1 -> lane_ready_o=0 until the fin edge; ready returns 1 the cycle after fin.
- Simultaneous acc and fin with hold empty: incoming word goes straight to sh; hold stays empty.
- Upstream may hold lane_valid_i with changing lane_i; only the value at the acc edge is captured.

## Test plan
- Reset: rst_i pulsed mid-cycle -> all outputs at reset values immediately, lane_ready_o=1.
- Single word: LANES=4, lane_i=4'ha one cycle, ser_ready_i=1 -> ser_o 0,1,0,1 on 4 consecutive cycles, ser_last_o=1 only on 4th, then ser_valid_o=0.
- Back-to-back: 4'ha then 4'h5 offered continuously, ser_ready_i=1 -> 8 contiguous valid bits 0,1,0,1,1,0,1,0, last on bits 4 and 8, no bubble.
- Backpressure: 4'hc, ser_ready_i toggled 1,0,0,1,1,0,1 -> serial stream exactly 0,0,1,1, ser_o stable during stalled cycles.
- Full: ser_ready_i=0, offer 4'h3, 4'h9, 4'h6 -> first two accepted, lane_ready_o=0 with 4'h6 pending; release ready -> 4'h6 accepted the cycle after first fin, output order 3,9,6.
- Reset mid-word: 4'hf, reset after 2 bits, then 4'h2 -> post-reset stream 0,1,0,0 only.
